// File: rtl/heat_sensor_master_if.sv
// Avalon-MM link between the heat-sensor master and the sensor's s0 slave port.
interface heat_sensor_master_if;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_read;
    logic [31:0] avm_m0_readdata;

    modport master (
        output avm_m0_write,
        output avm_m0_writedata,
        output avm_m0_read,
        input  avm_m0_readdata
    );

    modport slave (
        input  avm_m0_write,
        input  avm_m0_writedata,
        input  avm_m0_read,
        output avm_m0_readdata
    );
endinterface

// File: rtl/heat_sensor_master.sv
// Runs one measurement sequence on the heat sensor: enable, warm up, periodic reads,
// then always disable; tracks last/max/average temperature and overheat.
module heat_sensor_master #(
    parameter int WARMUP_CYCLES = 100,
    parameter int SAMPLE_PERIOD = 64,
    parameter int NSAMP_LOG2    = 4,
    parameter int READ_LATENCY  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic [31:0]                  threshold,
    heat_sensor_master_if.master         avm,
    output logic                         busy,
    output logic                         sample_valid,
    output logic [31:0]                  last_temp,
    output logic [31:0]                  max_temp,
    output logic [31:0]                  avg_temp,
    output logic                         overheat,
    output logic                         done
);

    localparam int SUM_W = 32 + NSAMP_LOG2;
    localparam int CNT_W = NSAMP_LOG2 + 1;
    localparam logic [CNT_W-1:0] NSAMP = CNT_W'(2 ** NSAMP_LOG2);

    typedef enum logic [3:0] {
        IDLE, EN_WR, WARMUP, RD_REQ, RD_WAIT, EVAL, GAP, DIS_WR, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [31:0]        thr_q, thr_d;
    logic [31:0]        last_q, last_d;
    logic [31:0]        max_q, max_d;
    logic [31:0]        avg_q, avg_d;
    logic               ovh_q, ovh_d;
    logic               normal_q, normal_d;
    logic               sv_q, sv_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               read_q, read_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 32'd1;
        samp_cnt_d = samp_cnt_q;
        sum_d      = sum_q;
        thr_d      = thr_q;
        last_d     = last_q;
        max_d      = max_q;
        avg_d      = avg_q;
        ovh_d      = ovh_q;
        normal_d   = normal_q;
        sv_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = EN_WR;
                    thr_d      = threshold;
                    max_d      = '0;
                    sum_d      = '0;
                    samp_cnt_d = '0;
                    ovh_d      = 1'b0;
                    normal_d   = 1'b0;
                end
            end
            EN_WR: begin
                state_d = WARMUP;
                timer_d = 32'd1;
            end
            WARMUP: begin
                if (timer_q == 32'(WARMUP_CYCLES))
                    state_d = RD_REQ;
            end
            // The timer counts cycles since the read strobe; it paces both capture and GAP.
            RD_REQ: begin
                state_d = RD_WAIT;
                timer_d = 32'd1;
            end
            RD_WAIT: begin
                if (!stop && timer_q == 32'(READ_LATENCY)) begin
                    state_d    = EVAL;
                    sv_d       = 1'b1;
                    last_d     = avm.avm_m0_readdata;
                    max_d      = (avm.avm_m0_readdata > max_q) ? avm.avm_m0_readdata : max_q;
                    sum_d      = sum_q + SUM_W'(avm.avm_m0_readdata);
                    samp_cnt_d = samp_cnt_q + 1'b1;
                    if (avm.avm_m0_readdata > thr_q)
                        ovh_d = 1'b1;
                end
            end
            EVAL: begin
                if (ovh_q) begin
                    state_d = DIS_WR;
                end else if (samp_cnt_q == NSAMP) begin
                    state_d  = DIS_WR;
                    normal_d = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (timer_q == 32'(SAMPLE_PERIOD - 1))
                    state_d = RD_REQ;
            end
            DIS_WR: begin
                state_d = DONE;
                if (normal_q)
                    avg_d = sum_q[NSAMP_LOG2 +: 32];
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort overrides whatever the active state decided, but a sample already
        // committed in EVAL stays in last/max/sum.
        if (stop && (state_q inside {EN_WR, WARMUP, RD_REQ, RD_WAIT, EVAL, GAP})) begin
            state_d  = DIS_WR;
            normal_d = 1'b0;
        end
    end

    always_comb begin
        busy_d  = state_d inside {EN_WR, WARMUP, RD_REQ, RD_WAIT, EVAL, GAP, DIS_WR};
        write_d = (state_d == EN_WR) || (state_d == DIS_WR);
        wdata_d = {31'd0, state_d == EN_WR};
        read_d  = (state_d == RD_REQ);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            samp_cnt_q <= '0;
            sum_q      <= '0;
            thr_q      <= '0;
            last_q     <= '0;
            max_q      <= '0;
            avg_q      <= '0;
            ovh_q      <= 1'b0;
            normal_q   <= 1'b0;
            sv_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            samp_cnt_q <= samp_cnt_d;
            sum_q      <= sum_d;
            thr_q      <= thr_d;
            last_q     <= last_d;
            max_q      <= max_d;
            avg_q      <= avg_d;
            ovh_q      <= ovh_d;
            normal_q   <= normal_d;
            sv_q       <= sv_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            read_q     <= read_d;
        end
    end

    assign avm.avm_m0_write     = write_q;
    assign avm.avm_m0_writedata = wdata_q;
    assign avm.avm_m0_read      = read_q;
    assign busy                 = busy_q;
    assign sample_valid         = sv_q;
    assign last_temp            = last_q;
    assign max_temp             = max_q;
    assign avg_temp             = avg_q;
    assign overheat             = ovh_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_heat_sensor_master.sv
// Scoreboard bench for heat_sensor_master: directed runs push expected bus/sample/done
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_heat_sensor_master;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_SV = 2;
    localparam int K_DN = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] threshold;
    logic        busy;
    logic        sample_valid;
    logic [31:0] last_temp;
    logic [31:0] max_temp;
    logic [31:0] avg_temp;
    logic        overheat;
    logic        done;

    int          checks;
    int          errors;
    int          cyc;
    int          base;
    ev_t         exp_q[$];
    logic [31:0] slave_q[$];

    heat_sensor_master_if bus ();

    heat_sensor_master #(
        .WARMUP_CYCLES (4),
        .SAMPLE_PERIOD (8),
        .NSAMP_LOG2    (2),
        .READ_LATENCY  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .threshold    (threshold),
        .avm          (bus.master),
        .busy         (busy),
        .sample_valid (sample_valid),
        .last_temp    (last_temp),
        .max_temp     (max_temp),
        .avg_temp     (avg_temp),
        .overheat     (overheat),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor slave with one cycle of read latency; junk data outside the valid cycle.
    always @(posedge clk) begin
        if (bus.avm_m0_read) begin
            if (slave_q.size() > 0)
                bus.avm_m0_readdata <= slave_q.pop_front();
            else
                bus.avm_m0_readdata <= 32'd0;
        end else begin
            bus.avm_m0_readdata <= 32'hDEAD_BEEF;
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_WR:    return "write";
            K_RD:    return "read";
            K_SV:    return "sample";
            K_DN:    return "done";
            default: return "none";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c, input logic [31:0] v0,
                           input logic [31:0] v1, input logic [31:0] v2);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.v0   = v0;
        e.v1   = v1;
        e.v2   = v2;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic [31:0] v0,
                               input logic [31:0] v1, input logic [31:0] v2);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_%s: got event at cycle %0d (%h/%h/%h), need no event",
                     kname(kind), cyc - base, v0, v1, v2);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc - base || e.v0 !== v0 || e.v1 !== v1 || e.v2 !== v2) begin
                errors++;
                $display("[TB] FAIL event_%s: got %s@%0d %h/%h/%h, need %s@%0d %h/%h/%h",
                         kname(e.kind), kname(kind), cyc - base, v0, v1, v2,
                         kname(e.kind), e.cyc, e.v0, e.v1, e.v2);
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, need %h", name, actual, expected);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: got %0d pending events, need 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        check_output({tag, "_last_temp"}, last_temp, 32'd0);
        check_output({tag, "_max_temp"}, max_temp, 32'd0);
        check_output({tag, "_avg_temp"}, avg_temp, 32'd0);
        check_output({tag, "_overheat"}, {31'd0, overheat}, 32'd0);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_write"}, {31'd0, bus.avm_m0_write}, 32'd0);
        check_output({tag, "_writedata"}, bus.avm_m0_writedata, 32'd0);
        check_output({tag, "_read"}, {31'd0, bus.avm_m0_read}, 32'd0);
    endtask

    // Monitor: every presented output is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((bus.avm_m0_read && bus.avm_m0_write) ||
                (!bus.avm_m0_write && bus.avm_m0_writedata != 32'd0)) begin
                errors++;
                $display("[TB] FAIL bus_rules: got read=%b write=%b writedata=%h, need exclusive strobes and idle writedata 0",
                         bus.avm_m0_read, bus.avm_m0_write, bus.avm_m0_writedata);
            end
            if (bus.avm_m0_write)
                check_event(K_WR, bus.avm_m0_writedata, {31'd0, busy}, 32'd0);
            if (bus.avm_m0_read)
                check_event(K_RD, {31'd0, busy}, 32'd0, 32'd0);
            if (sample_valid)
                check_event(K_SV, last_temp, max_temp, {31'd0, overheat});
            if (done)
                check_event(K_DN, avg_temp, {31'd0, overheat}, {31'd0, busy});
        end
    end

    // Expected events of a full four-sample run with reads at 6, 14, 22, 30.
    task automatic expect_full_run(input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [31:0] d2, input logic [31:0] d3,
                                   input logic [31:0] m0, input logic [31:0] m1,
                                   input logic [31:0] m2, input logic [31:0] m3,
                                   input logic [31:0] avg);
        push_ev(K_WR, 1, 32'd1, 32'd1, 32'd0);
        push_ev(K_RD, 6, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 8, d0, m0, 32'd0);
        push_ev(K_RD, 14, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 16, d1, m1, 32'd0);
        push_ev(K_RD, 22, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 24, d2, m2, 32'd0);
        push_ev(K_RD, 30, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 32, d3, m3, 32'd0);
        push_ev(K_WR, 33, 32'd0, 32'd1, 32'd0);
        push_ev(K_DN, 34, avg, 32'd0, 32'd0);
    endtask

    // Start pulse at relative cycle 0, then optional stop/extra-start pulses up to run_len.
    task automatic apply_stimulus(input logic [31:0] thr, input int stop_at,
                                  input int restart_a, input int restart_b, input int run_len);
        @(negedge clk);
        threshold = thr;
        start     = 1'b1;
        base      = cyc;
        for (int i = 1; i <= run_len; i++) begin
            @(negedge clk);
            start = (i == restart_a) || (i == restart_b);
            stop  = (i == stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        base      = 0;
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        threshold = 32'd0;
        bus.avm_m0_readdata = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] normal run");
        slave_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        expect_full_run(32'd10, 32'd20, 32'd30, 32'd40,
                        32'd10, 32'd20, 32'd30, 32'd40, 32'd25);
        apply_stimulus(32'd1000, 0, 0, 0, 36);
        check_drained("normal");
        check_output("normal_max_temp", max_temp, 32'd40);

        $display("[TB] overheat run");
        slave_q = '{32'd10, 32'd2000, 32'd30, 32'd40};
        push_ev(K_WR, 1, 32'd1, 32'd1, 32'd0);
        push_ev(K_RD, 6, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 8, 32'd10, 32'd10, 32'd0);
        push_ev(K_RD, 14, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 16, 32'd2000, 32'd2000, 32'd1);
        push_ev(K_WR, 17, 32'd0, 32'd1, 32'd0);
        push_ev(K_DN, 18, 32'd25, 32'd1, 32'd0);
        apply_stimulus(32'd1000, 0, 0, 0, 24);
        check_drained("overheat");
        check_output("overheat_sticky", {31'd0, overheat}, 32'd1);

        $display("[TB] abort run");
        slave_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        push_ev(K_WR, 1, 32'd1, 32'd1, 32'd0);
        push_ev(K_RD, 6, 32'd1, 32'd0, 32'd0);
        push_ev(K_SV, 8, 32'd10, 32'd10, 32'd0);
        push_ev(K_WR, 11, 32'd0, 32'd1, 32'd0);
        push_ev(K_DN, 12, 32'd25, 32'd0, 32'd0);
        apply_stimulus(32'd1000, 10, 0, 0, 24);
        check_drained("abort");

        $display("[TB] reset mid-run");
        slave_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        push_ev(K_WR, 1, 32'd1, 32'd1, 32'd0);
        push_ev(K_RD, 6, 32'd1, 32'd0, 32'd0);
        apply_stimulus(32'd1000, 0, 0, 0, 7);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_all_zero("midrun_reset");
        check_drained("midrun_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        slave_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        expect_full_run(32'd5, 32'd6, 32'd7, 32'd8,
                        32'd5, 32'd6, 32'd7, 32'd8, 32'd6);
        apply_stimulus(32'd1000, 0, 0, 0, 36);
        check_drained("after_reset");

        $display("[TB] repeated start during run");
        slave_q = '{32'd3, 32'd1, 32'd4, 32'd2};
        expect_full_run(32'd3, 32'd1, 32'd4, 32'd2,
                        32'd3, 32'd3, 32'd4, 32'd4, 32'd2);
        apply_stimulus(32'd1000, 0, 3, 20, 36);
        check_drained("restart_ignored");

        $display("[TB] start with stop in idle");
        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (20) @(negedge clk);
        check_drained("start_stop");
        check_output("start_stop_busy", {31'd0, busy}, 32'd0);

        $display("[TB] all-ones samples");
        slave_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        expect_full_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFF);
        apply_stimulus(32'hFFFF_FFFF, 0, 0, 0, 36);
        check_drained("all_ones");
        check_output("all_ones_overheat", {31'd0, overheat}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/heat_sensor_master.md
# heat_sensor_master

Avalon-MM master that drives the heat-sensor slave through a complete measurement run. On a start pulse it enables the heat generator (write 1), waits a warm-up interval, then takes a fixed number of periodically spaced sensor reads. It tracks last/max/average temperature and aborts on over-threshold or external stop. It always disables the generator (write 0) before finishing. It sits between a host control register block and the sensor's s0 slave port.

## Interface
- WARMUP_CYCLES, 100, idle cycles between the enable write and the first read (≥1)
- SAMPLE_PERIOD, 64, cycles between consecutive read strobes (≥ READ_LATENCY+3)
- NSAMP_LOG2, 4, log2 of samples per run (2^NSAMP_LOG2 reads)
- READ_LATENCY, 1, fixed slave read latency in cycles (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request; ignored while busy
- stop  in  1  abort request; level-sampled each cycle
- threshold  in  32  overheat limit, captured on accepted start
- avm_m0_write  out  1  write strobe to sensor
- avm_m0_writedata  out  32  1 = enable generator, 0 = disable
- avm_m0_read  out  1  read strobe to sensor
- avm_m0_readdata  in  32  sensor value, valid READ_LATENCY cycles after read
- busy  out  1  run in progress
- sample_valid  out  1  one-cycle pulse, last_temp updated
- last_temp  out  32  most recent sample
- max_temp  out  32  maximum sample of the current run
- avg_temp  out  32  mean of the last completed run
- overheat  out  1  sticky until next accepted start
- done  out  1  one-cycle pulse at end of every run (normal, overheat or abort)

## Operation
- States: IDLE, EN_WR, WARMUP, RD_REQ, RD_WAIT, EVAL, GAP, DIS_WR, DONE.
- IDLE: all strobes low.
  - On start: capture threshold, clear max_temp, sum, sample count and overheat, then go to EN_WR.
- EN_WR: one cycle, write=1, writedata=1. Then WARMUP for WARMUP_CYCLES cycles, then RD_REQ.
- RD_REQ: one cycle, read=1. RD_WAIT: readdata is captured in the cycle READ_LATENCY after the read strobe.
- EVAL (cycle after capture): last_temp←sample, sample_valid=1, max_temp←max(max_temp,sample), sum+=sample.
  - sample > threshold (unsigned, strict): overheat=1, go DIS_WR.
  - Else if this is sample 2^NSAMP_LOG2: go DIS_WR, flag normal completion.
  - Else: GAP until the next read strobe, exactly SAMPLE_PERIOD cycles after the previous one.
- DIS_WR: one cycle, write=1, writedata=0. Then DONE.
- DONE: one cycle, done=1. On normal completion avg_temp←sum>>NSAMP_LOG2 (truncate); otherwise avg_temp holds. Then IDLE.
- Sum register width is 32+NSAMP_LOG2; no overflow possible.
- stop high in EN_WR, WARMUP, RD_REQ, RD_WAIT, EVAL or GAP: go to DIS_WR next cycle.
  - Any in-flight read data is discarded; stop in EVAL still commits that sample.
- stop in DIS_WR/DONE/IDLE: no effect.
- If start and stop are high together in IDLE, stop wins: no run.
- read and write are never asserted in the same cycle. writedata is 0 whenever write is low.

## Timing
- Reset (asynchronous, reset=0): state IDLE. All outputs 0, including avg_temp, max_temp, last_temp and overheat. No bus strobe is issued.
- Reset asserted mid-run: strobes drop immediately. No disable write is issued; the host must re-run after reset.
- start at cycle 0 → write/writedata=1 at cycle 1. busy=1 from cycle 1 through the DIS_WR cycle inclusive.
- First read at cycle WARMUP_CYCLES+2. Read k (k=0..) is at cycle WARMUP_CYCLES+2+k·SAMPLE_PERIOD.
- Read at cycle R → data captured at R+READ_LATENCY → sample_valid/last_temp at R+READ_LATENCY+1.
- After the final/overheat EVAL cycle E: disable write at E+1, done at E+2, busy=0 at E+2.
- stop at cycle S (qualifying state): disable write at S+1, done at S+2.
- start on the same cycle as done is ignored. The earliest new start is accepted at E+3.
- All outputs are registered.

## Test plan
All scenarios use WARMUP_CYCLES=4, SAMPLE_PERIOD=8, NSAMP_LOG2=2, READ_LATENCY=1, threshold=1000.
- Normal run, slave returns 10,20,30,40: enable write at cycle 1; reads at 6,14,22,30; disable write at 33; done at 34; max_temp=40, avg_temp=25, overheat=0.
- Overheat, slave returns 10,2000: second sample_valid at 16, overheat=1, disable write at 17, done at 18. Only 2 reads issued; avg_temp holds previous value.
- Abort, stop pulsed at cycle 10 (GAP): disable write at 11, done at 12, no further reads, overheat=0.
- Reset mid-run, reset low at cycle 8: all outputs 0 asynchronously. A new start after release runs a full normal sequence.
- start repeated at cycles 3 and 20 during a run is ignored (single enable write). Simultaneous start+stop in IDLE → no bus activity.
- Values 0xFFFFFFFF×4 with threshold=0xFFFFFFFF: no overheat, avg_temp=0xFFFFFFFF (sum width check).
